// File: rtl/xbar_pkg.sv
// ======================================================================
// xbar_pkg : shared constants, FSM encoding and round-robin helper
// Rev 1.0
// ======================================================================
`default_nettype none

package xbar_pkg;

    localparam int N_MST = 2;
    localparam int N_SLV = 2;
    localparam int MST_W = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    // With two candidates the master that was not served last wins.
    function automatic logic [MST_W-1:0] rr_pick(input logic [N_MST-1:0] cand,
                                                 input logic [MST_W-1:0] last);
        if (cand[0] && cand[1]) begin
            return ~last;
        end
        return MST_W'(cand[1]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/xbar_arbiter_if.sv
// ======================================================================
// xbar_arbiter_if : master request / slave route bundle for the arbiter
// Rev 1.0
// ======================================================================
`default_nettype none

interface xbar_arbiter_if;
    import xbar_pkg::*;

    logic [N_MST-1:0] m_req;
    logic [N_MST-1:0] m_dst;
    logic [N_MST-1:0] m_gnt;
    logic [N_SLV-1:0] s_ack;
    logic [N_SLV-1:0] sel;
    logic [N_SLV-1:0] s_en;
    logic [N_SLV-1:0] tout;

    modport slave  (input  m_req, m_dst, s_ack, output sel, s_en, m_gnt, tout);
    modport master (output m_req, m_dst, s_ack, input  sel, s_en, m_gnt, tout);

endinterface

`default_nettype wire

// File: rtl/xbar_slave_arb.sv
// ======================================================================
// xbar_slave_arb : per-slave grant FSM with round-robin and timeout
// Rev 1.0
// ======================================================================
`default_nettype none

module xbar_slave_arb
    import xbar_pkg::*;
#(
    parameter int TOUT_W   = 8,
    parameter int TOUT_CYC = 200
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [N_MST-1:0] cand,
    input  wire logic [N_MST-1:0] m_req,
    input  wire logic             s_ack,
    output logic      [MST_W-1:0] sel,
    output logic                  s_en,
    output logic                  tout
);

    localparam bit               C_TOUT_EN   = (TOUT_CYC > 0);
    localparam logic [TOUT_W-1:0] C_TOUT_LAST = TOUT_W'((TOUT_CYC > 0) ? TOUT_CYC - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic [MST_W-1:0]  sel_q, sel_d;
    logic [MST_W-1:0]  rr_q, rr_d;
    logic [TOUT_W-1:0] cnt_q, cnt_d;
    logic              tout_q, tout_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    // sel_q doubles as the owner index while BUSY and holds through REL/IDLE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    sel_d   = rr_pick(cand, rr_q);
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_ack) begin
                    state_d = ST_REL;
                    rr_d    = sel_q;
                end else if (!m_req[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (C_TOUT_EN && (cnt_q == C_TOUT_LAST)) begin
                    state_d = ST_REL;
                    tout_d  = 1'b1;
                    rr_d    = sel_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TOUT_W'(1);
                end
            end
            ST_REL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel  = sel_q;
        s_en = (state_q == ST_BUSY);
        tout = tout_q;
    end

endmodule

`default_nettype wire

// File: rtl/xbar_arbiter.sv
// ======================================================================
// xbar_arbiter : 2x2 crossbar route arbiter, one FSM per slave
// Rev 1.0
// ======================================================================
`default_nettype none

module xbar_arbiter
    import xbar_pkg::*;
#(
    parameter int TOUT_W   = 8,
    parameter int TOUT_CYC = 200
) (
    input wire logic       clk,
    input wire logic       reset,
    xbar_arbiter_if.slave  bus
);

    logic [N_SLV-1:0] w_sel;
    logic [N_SLV-1:0] w_s_en;
    logic [N_SLV-1:0] w_tout;
    logic [N_MST-1:0] w_gnt;

    for (genvar s = 0; s < N_SLV; s++) begin : g_slv
        logic [N_MST-1:0] w_cand;

        // An idle master's address is don't-care; the AND keeps X out of the FSM.
        always_comb begin
            for (int m = 0; m < N_MST; m++) begin
                w_cand[m] = bus.m_req[m] & (bus.m_dst[m] == 1'(s));
            end
        end

        xbar_slave_arb #(
            .TOUT_W   (TOUT_W),
            .TOUT_CYC (TOUT_CYC)
        ) u_arb (
            .clk   (clk),
            .reset (reset),
            .cand  (w_cand),
            .m_req (bus.m_req),
            .s_ack (bus.s_ack[s]),
            .sel   (w_sel[s]),
            .s_en  (w_s_en[s]),
            .tout  (w_tout[s])
        );
    end

    always_comb begin
        w_gnt = '0;
        for (int s = 0; s < N_SLV; s++) begin
            for (int m = 0; m < N_MST; m++) begin
                if (w_s_en[s] && (w_sel[s] == 1'(m))) begin
                    w_gnt[m] = 1'b1;
                end
            end
        end
    end

    assign bus.sel   = w_sel;
    assign bus.s_en  = w_s_en;
    assign bus.tout  = w_tout;
    assign bus.m_gnt = w_gnt;

endmodule

`default_nettype wire

// File: tb/tb_xbar_arbiter.sv
// ======================================================================
// tb_xbar_arbiter : directed self-checking bench, outputs packed {s_en,m_gnt,sel,tout}
// Rev 1.0
// ======================================================================
`default_nettype none

module tb_xbar_arbiter;
    import xbar_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    xbar_arbiter_if bus();

    xbar_arbiter #(
        .TOUT_W   (8),
        .TOUT_CYC (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {bus.s_en, bus.m_gnt, bus.sel, bus.tout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] dst, input logic [1:0] ack);
        bus.m_req = req;
        bus.m_dst = dst;
        bus.s_ack = ack;
    endtask

    task automatic apply_reset();
        drive(2'b00, 2'b00, 2'b00);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(2'b00, 2'b00, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL reset_exit got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
    endtask

    task automatic test_single();
        drive(2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== 8'b01_01_00_00) begin
                failures++;
                $display("FAIL single_busy[%0d] got=%b exp=%b", i, obs(), 8'b01_01_00_00);
            end
        end
        drive(2'b01, 2'b00, 2'b01);
        step();
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL single_rel got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
        drive(2'b00, 2'b00, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL single_idle got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
    endtask

    task automatic test_ack_idle();
        apply_reset();
        drive(2'b00, 2'bxx, 2'b11);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs() !== 8'b00_00_00_00) begin
                failures++;
                $display("FAIL ackidle_quiet[%0d] got=%b exp=%b", i, obs(), 8'b00_00_00_00);
            end
        end
        drive(2'b10, 2'b10, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b10_10_10_00) begin
            failures++;
            $display("FAIL ackidle_grant got=%b exp=%b", obs(), 8'b10_10_10_00);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g [3];
        logic [7:0] exp_r [3];
        exp_g[0] = 8'b01_10_01_00;  exp_r[0] = 8'b00_00_01_00;
        exp_g[1] = 8'b01_01_00_00;  exp_r[1] = 8'b00_00_00_00;
        exp_g[2] = 8'b01_10_01_00;  exp_r[2] = 8'b00_00_01_00;
        apply_reset();
        drive(2'b11, 2'b00, 2'b00);
        for (int g = 0; g < 3; g++) begin
            step();
            checks++;
            if (obs() !== exp_g[g]) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", g, obs(), exp_g[g]);
            end
            step();
            drive(2'b11, 2'b00, 2'b01);
            step();
            checks++;
            if (obs() !== exp_r[g]) begin
                failures++;
                $display("FAIL rr_rel[%0d] got=%b exp=%b", g, obs(), exp_r[g]);
            end
            drive(2'b11, 2'b00, 2'b00);
            step();
            checks++;
            if (obs() !== exp_r[g]) begin
                failures++;
                $display("FAIL rr_idle[%0d] got=%b exp=%b", g, obs(), exp_r[g]);
            end
        end
    endtask

    task automatic test_parallel();
        apply_reset();
        drive(2'b11, 2'b10, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b11_11_10_00) begin
            failures++;
            $display("FAIL par_grant got=%b exp=%b", obs(), 8'b11_11_10_00);
        end
        drive(2'b11, 2'b10, 2'b11);
        step();
        checks++;
        if (obs() !== 8'b00_00_10_00) begin
            failures++;
            $display("FAIL par_rel got=%b exp=%b", obs(), 8'b00_00_10_00);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        drive(2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs() !== 8'b01_01_00_00) begin
                failures++;
                $display("FAIL tout_busy[%0d] got=%b exp=%b", i, obs(), 8'b01_01_00_00);
            end
        end
        step();
        checks++;
        if (obs() !== 8'b00_00_00_01) begin
            failures++;
            $display("FAIL tout_pulse got=%b exp=%b", obs(), 8'b00_00_00_01);
        end
        step();
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL tout_idle got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
        step();
        checks++;
        if (obs() !== 8'b01_01_00_00) begin
            failures++;
            $display("FAIL tout_regrant got=%b exp=%b", obs(), 8'b01_01_00_00);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        drive(2'b01, 2'b00, 2'b00);
        step();
        drive(2'b00, 2'b00, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL abort_drop got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
        drive(2'b11, 2'b00, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b01_10_01_00) begin
            failures++;
            $display("FAIL abort_rr got=%b exp=%b", obs(), 8'b01_10_01_00);
        end
    endtask

    task automatic test_ack_priority();
        apply_reset();
        drive(2'b10, 2'b00, 2'b00);
        step();
        drive(2'b00, 2'b00, 2'b01);
        step();
        checks++;
        if (obs() !== 8'b00_00_01_00) begin
            failures++;
            $display("FAIL prio_rel got=%b exp=%b", obs(), 8'b00_00_01_00);
        end
        drive(2'b11, 2'b00, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b00_00_01_00) begin
            failures++;
            $display("FAIL prio_gap got=%b exp=%b", obs(), 8'b00_00_01_00);
        end
        step();
        checks++;
        if (obs() !== 8'b01_01_00_00) begin
            failures++;
            $display("FAIL prio_rr got=%b exp=%b", obs(), 8'b01_01_00_00);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(2'b11, 2'b10, 2'b00);
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL arst_now got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
        step();
        reset = 1'b0;
        drive(2'b00, 2'b00, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b00_00_00_00) begin
            failures++;
            $display("FAIL arst_idle got=%b exp=%b", obs(), 8'b00_00_00_00);
        end
        drive(2'b11, 2'b00, 2'b00);
        step();
        checks++;
        if (obs() !== 8'b01_10_01_00) begin
            failures++;
            $display("FAIL arst_rr got=%b exp=%b", obs(), 8'b01_10_01_00);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ack_idle();
        test_round_robin();
        test_parallel();
        test_timeout();
        test_abort();
        test_ack_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
